// File: rtl/bw_mult_seq.sv
// bw_mult_seq
// -----------------------------------------------------------------------------
// Iterative signed N x N Baugh-Wooley multiplier. A single row of N cells
// (AND / NAND partial-product generators feeding full adders) is reused once
// per clock. Carry-save sum/carry registers hold the running partial result,
// and the sum LSB shifts into the low half of the product each row. A final
// cycle ripple-adds the sum and carry vectors, together with the Baugh-Wooley
// correction constant, to form the 2N-bit two's-complement product.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   a_in       multiplicand (signed, N bits)
//   b_in       multiplier   (signed, N bits)
//   in_valid   operands present
//   in_ready   block can accept operands this cycle (combinational)
//   p_out      signed product (2N bits), qualified by out_valid
//   out_valid  p_out holds a valid result
//   out_ready  consumer accepts p_out this cycle
// -----------------------------------------------------------------------------
module bw_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N-1:0] p_out,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_FINAL   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Correction terms: +2^N and +2^(2N-1), modulo 2^(2N).
  localparam logic [2*N-1:0] BW_CORR = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [N-1:0]   carry_q, carry_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [CW-1:0]  row_q, row_d;
  logic [2*N-1:0] p_q, p_d;
  logic           out_valid_q, out_valid_d;

  logic           accept;
  logic           last_row;
  logic           b_j;
  logic [N-1:0]   sum_in;
  logic [N-1:0]   pp;
  logic [N-1:0]   row_sum;
  logic [N-1:0]   row_carry;
  logic [N-1:0]   hi;
  logic [2*N-1:0] p_final;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign last_row = (row_q == CW'(N - 1));
  assign b_j      = b_q[row_q];

  // Previous row's sum, shifted down one place to align with this row's
  // weights; the top cell has no sum input.
  assign sum_in = {1'b0, sum_q[N-1:1]};

  // One row of cells. The partial product is inverted (NAND) when exactly one
  // of "top column" / "top row" holds; the corner cell stays a plain AND.
  always_comb begin
    pp        = '0;
    row_sum   = '0;
    row_carry = '0;
    for (int i = 0; i < N; i++) begin
      pp[i] = (a_q[i] & b_j) ^ ((i == N - 1) != last_row);
      {row_carry[i], row_sum[i]} = full_add(pp[i], sum_in[i], carry_q[i]);
    end
  end

  // Carry-propagate of the remaining high half plus correction constant.
  assign hi      = sum_in + carry_q;
  assign p_final = {hi, lo_q} + BW_CORR;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    lo_d        = lo_q;
    row_d       = row_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        sum_d   = row_sum;
        carry_d = row_carry;
        lo_d    = {row_sum[0], lo_q[N-1:1]};
        row_d   = row_q + CW'(1);
        if (last_row) state_d = S_FINAL;
      end
      S_FINAL: begin
        p_d         = p_final;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? S_COMPUTE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept is only possible in IDLE or in DONE with out_ready, so loading
    // here never disturbs an operation in flight.
    if (accept) begin
      a_d     = a_in;
      b_d     = b_in;
      row_d   = '0;
      sum_d   = '0;
      carry_d = '0;
      lo_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      lo_q        <= '0;
      row_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      lo_q        <= lo_d;
      row_q       <= row_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p_out     = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bw_mult_seq.sv
module tb_bw_mult_seq;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] p_out;
  logic           out_valid;
  logic           out_ready;

  int errs;
  int checks;
  int n_acc;
  int n_res;

  bw_mult_seq #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p_out    (p_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid after an accept edge; returns edges counted.
  task automatic wait_result(input bit scramble, output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      if (scramble) begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      step();
      lat++;
    end
    if (out_valid) n_res++;
  endtask

  // One full transaction from IDLE: accept, wait, optional stall, handshake.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input string tag, input bit scramble, input int stall);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    step();
    n_acc++;
    in_valid = 1'b0;
    wait_result(scramble, lat);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check(tag, 32'(p_out), 32'(exp));
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] vals [16];
    logic signed [7:0] sa, sb;
    logic signed [15:0] e16;

    errs      = 0;
    checks    = 0;
    n_acc     = 0;
    n_res     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a_in      = 8'h80;
    b_in      = 8'h80;
    out_ready = 1'b0;

    // Reset held for two edges with in_valid asserted.
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p_out", 32'(p_out), 32'h0000);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Extremes.
    do_op(8'h80, 8'h80, 16'h4000, "min_x_min", 1'b0, 0);
    check("ovld_clear", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("p_held_after_hs", 32'(p_out), 32'h4000);
    do_op(8'h7F, 8'h80, 16'hC080, "max_x_min", 1'b0, 0);
    do_op(8'hFF, 8'h01, 16'hFFFF, "m1_x_1", 1'b0, 0);
    do_op(8'h00, 8'hB3, 16'h0000, "zero_x", 1'b0, 0);

    // Backpressure: 5 * -3 held for 5 cycles, stray (2,2) pulse ignored.
    in_valid = 1'b1;
    a_in     = 8'h05;
    b_in     = 8'hFD;
    step();
    n_acc++;
    in_valid = 1'b0;
    wait_result(1'b0, lat);
    check("bp_latency", 32'(lat), 32'd9);
    for (int k = 0; k < 5; k++) begin
      check("bp_p_out", 32'(p_out), 32'hFFF1);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = (k == 2);
      a_in     = 8'h02;
      b_in     = 8'h02;
      step();
    end
    in_valid = 1'b0;
    check("bp_after_hold", 32'(p_out), 32'hFFF1);
    // Back-to-back: result handshake and new accept on the same edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 8'h02;
    b_in      = 8'h02;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    n_acc++;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_ovld_drop", 32'(out_valid), 32'd0);
    check("b2b_busy", 32'(in_ready), 32'd0);
    wait_result(1'b0, lat);
    check("b2b_latency", 32'(lat), 32'd9);
    check("b2b_p_out", 32'(p_out), 32'h0004);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Operand isolation: inputs scrambled every cycle during COMPUTE.
    do_op(8'h03, 8'hFB, 16'hFFF1, "isolate", 1'b1, 0);

    // Reset in the middle of 100 * 100.
    in_valid = 1'b1;
    a_in     = 8'd100;
    b_in     = 8'd100;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_idle", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    do_op(8'h03, 8'hFB, 16'hFFF1, "after_rst", 1'b0, 0);

    // Corner-value sweep with random consumer stalls.
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h7E, 8'h80, 8'h81,
             8'hFF, 8'hFE, 8'h55, 8'hAA, 8'h40, 8'hC0, 8'h0F, 8'hF0};
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sa  = vals[i];
        sb  = vals[j];
        e16 = sa * sb;
        do_op(vals[i], vals[j], e16, $sformatf("mul_%02h_%02h", vals[i], vals[j]),
              1'b0, int'($urandom_range(0, 3)));
      end
    end
    check("result_count", 32'(n_res), 32'(n_acc));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
